// File: rtl/sa_aw_arbiter.sv
// Slave-side AW arbiter: round-robin pick among dispatcher requests, one-entry
// registered slave AW stage, and same-cycle ordering pushes to the B/W trackers.
module sa_aw_arbiter #(
    parameter int unsigned MST_AMT        = 3,
    parameter int unsigned MST_ID_W       = (MST_AMT > 1) ? $clog2(MST_AMT) : 1,
    parameter int unsigned TRANS_MST_ID_W = 5,
    parameter int unsigned TRANS_SLV_ID_W = TRANS_MST_ID_W + MST_ID_W,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LEN_W          = 8
) (
    input  logic                              ACLK_i,
    input  logic                              ARESETn_i,
    input  logic [TRANS_MST_ID_W*MST_AMT-1:0] dsp_AWID_i,
    input  logic [ADDR_W*MST_AMT-1:0]         dsp_AWADDR_i,
    input  logic [LEN_W*MST_AMT-1:0]          dsp_AWLEN_i,
    input  logic [MST_AMT-1:0]                dsp_AWVALID_i,
    output logic [MST_AMT-1:0]                dsp_AWREADY_o,
    output logic [TRANS_SLV_ID_W-1:0]         s_AWID_o,
    output logic [ADDR_W-1:0]                 s_AWADDR_o,
    output logic [LEN_W-1:0]                  s_AWLEN_o,
    output logic                              s_AWVALID_o,
    input  logic                              s_AWREADY_i,
    output logic [TRANS_SLV_ID_W-1:0]         AW_AxID_o,
    output logic                              AW_crossing_flag_o,
    output logic                              AW_shift_en_o,
    input  logic                              AW_stall_i,
    output logic [MST_ID_W-1:0]               W_mst_id_o,
    output logic                              W_shift_en_o,
    input  logic                              W_stall_i
);

    logic [MST_ID_W-1:0]       rr_ptr;
    logic [MST_ID_W-1:0]       last_mst;
    logic                      last_valid;
    logic [MST_ID_W-1:0]       sel;
    logic                      hit;
    logic [TRANS_MST_ID_W-1:0] sel_id;
    logic [ADDR_W-1:0]         sel_addr;
    logic [LEN_W-1:0]          sel_len;
    logic                      slot_free;
    logic                      grant_en;

    // Round-robin: first requester above rr_ptr, otherwise wrap to the lowest one.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < int'(MST_AMT); i++) begin
            if (!hit && dsp_AWVALID_i[i] && (i > int'(rr_ptr))) begin
                hit = 1'b1;
                sel = MST_ID_W'(i);
            end
        end
        for (int i = 0; i < int'(MST_AMT); i++) begin
            if (!hit && dsp_AWVALID_i[i] && (i <= int'(rr_ptr))) begin
                hit = 1'b1;
                sel = MST_ID_W'(i);
            end
        end
    end

    // Payload mux for the selected master.
    always_comb begin
        sel_id   = '0;
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < int'(MST_AMT); i++) begin
            if (sel == MST_ID_W'(i)) begin
                sel_id   = dsp_AWID_i[i*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                sel_addr = dsp_AWADDR_i[i*ADDR_W +: ADDR_W];
                sel_len  = dsp_AWLEN_i[i*LEN_W +: LEN_W];
            end
        end
    end

    assign slot_free = !s_AWVALID_o || s_AWREADY_i;
    // Reset gating keeps the combinational handshake/push outputs quiet during reset.
    assign grant_en  = ARESETn_i && slot_free && !AW_stall_i && !W_stall_i && hit;

    always_comb begin
        dsp_AWREADY_o      = '0;
        for (int i = 0; i < int'(MST_AMT); i++) begin
            dsp_AWREADY_o[i] = grant_en && (sel == MST_ID_W'(i));
        end
        AW_shift_en_o      = grant_en;
        W_shift_en_o       = grant_en;
        AW_AxID_o          = grant_en ? {sel, sel_id} : '0;
        W_mst_id_o         = grant_en ? sel : '0;
        AW_crossing_flag_o = grant_en && last_valid && (sel != last_mst);
    end

    // One-entry slave AW stage plus arbitration history.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            s_AWVALID_o <= 1'b0;
            s_AWID_o    <= '0;
            s_AWADDR_o  <= '0;
            s_AWLEN_o   <= '0;
            rr_ptr      <= MST_ID_W'(MST_AMT - 1);
            last_mst    <= '0;
            last_valid  <= 1'b0;
        end else if (grant_en) begin
            s_AWVALID_o <= 1'b1;
            s_AWID_o    <= {sel, sel_id};
            s_AWADDR_o  <= sel_addr;
            s_AWLEN_o   <= sel_len;
            rr_ptr      <= sel;
            last_mst    <= sel;
            last_valid  <= 1'b1;
        end else if (s_AWREADY_i) begin
            s_AWVALID_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sa_aw_arbiter.sv
// Self-checking bench for sa_aw_arbiter: per-scenario inline checks plus a
// queue scoreboard that checks every slave AW beat against the granted payload.
module tb_sa_aw_arbiter;

    localparam int unsigned NM  = 3;
    localparam int unsigned MW  = 2;
    localparam int unsigned TW  = 5;
    localparam int unsigned SW  = 7;
    localparam int unsigned AW  = 32;
    localparam int unsigned LW  = 8;

    typedef struct packed {
        logic [SW-1:0] id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } aw_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [TW-1:0] mid [NM];
    logic [AW-1:0] maddr [NM];
    logic [LW-1:0] mlen [NM];
    logic [TW*NM-1:0] awid_bus;
    logic [AW*NM-1:0] awaddr_bus;
    logic [LW*NM-1:0] awlen_bus;
    logic [NM-1:0] valid;
    logic [NM-1:0] dsp_AWREADY_o;
    logic [SW-1:0] s_AWID_o;
    logic [AW-1:0] s_AWADDR_o;
    logic [LW-1:0] s_AWLEN_o;
    logic s_AWVALID_o;
    logic s_ready;
    logic [SW-1:0] AW_AxID_o;
    logic AW_crossing_flag_o;
    logic AW_shift_en_o;
    logic aw_stall;
    logic [MW-1:0] W_mst_id_o;
    logic W_shift_en_o;
    logic w_stall;

    aw_t q[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < int'(NM); i++) begin
            awid_bus[i*TW +: TW]   = mid[i];
            awaddr_bus[i*AW +: AW] = maddr[i];
            awlen_bus[i*LW +: LW]  = mlen[i];
        end
    end

    sa_aw_arbiter dut (
        .ACLK_i            (clk),
        .ARESETn_i         (rst_n),
        .dsp_AWID_i        (awid_bus),
        .dsp_AWADDR_i      (awaddr_bus),
        .dsp_AWLEN_i       (awlen_bus),
        .dsp_AWVALID_i     (valid),
        .dsp_AWREADY_o     (dsp_AWREADY_o),
        .s_AWID_o          (s_AWID_o),
        .s_AWADDR_o        (s_AWADDR_o),
        .s_AWLEN_o         (s_AWLEN_o),
        .s_AWVALID_o       (s_AWVALID_o),
        .s_AWREADY_i       (s_ready),
        .AW_AxID_o         (AW_AxID_o),
        .AW_crossing_flag_o(AW_crossing_flag_o),
        .AW_shift_en_o     (AW_shift_en_o),
        .AW_stall_i        (aw_stall),
        .W_mst_id_o        (W_mst_id_o),
        .W_shift_en_o      (W_shift_en_o),
        .W_stall_i         (w_stall)
    );

    // Scoreboard: slave stage must present the oldest granted payload, popped on handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            tests++;
            if (s_AWVALID_o !== (q.size() != 0)) begin
                fails++;
                $display("FAIL sb_valid: got %b exp %b", s_AWVALID_o, q.size() != 0);
            end
            if (q.size() != 0) begin
                tests++;
                if ({s_AWID_o, s_AWADDR_o, s_AWLEN_o} !== q[0]) begin
                    fails++;
                    $display("FAIL sb_payload: got %h/%h/%h exp %h/%h/%h",
                             s_AWID_o, s_AWADDR_o, s_AWLEN_o, q[0].id, q[0].addr, q[0].len);
                end
                if (s_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish exp finish");
        $fatal(1, "timeout");
    end

    // Advance one cycle; on a grant, record the payload the slave stage must carry.
    task automatic commit(input bit gnt, input int g);
        aw_t e;
        @(posedge clk);
        #1;
        if (gnt) begin
            e.id   = {MW'(g), mid[g]};
            e.addr = maddr[g];
            e.len  = mlen[g];
            q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        valid    = '0;
        s_ready  = 1'b1;
        aw_stall = 1'b0;
        w_stall  = 1'b0;
        q.delete();
        for (int i = 0; i < int'(NM); i++) begin
            mid[i]   = TW'(i + 8);
            maddr[i] = 32'h1000 * (i + 1);
            mlen[i]  = LW'(i + 1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        valid = 3'b111;
        #2;
        tests++;
        if ({dsp_AWREADY_o, AW_shift_en_o, W_shift_en_o, AW_crossing_flag_o} !== 6'b0) begin
            fails++;
            $display("FAIL reset_comb: got %b exp 000000",
                     {dsp_AWREADY_o, AW_shift_en_o, W_shift_en_o, AW_crossing_flag_o});
        end
        tests++;
        if ({s_AWVALID_o, s_AWID_o, s_AWADDR_o, s_AWLEN_o, AW_AxID_o, W_mst_id_o} !== '0) begin
            fails++;
            $display("FAIL reset_regs: got %b/%h/%h/%h/%h/%h exp zeros",
                     s_AWVALID_o, s_AWID_o, s_AWADDR_o, s_AWLEN_o, AW_AxID_o, W_mst_id_o);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        valid = 3'b010; mid[1] = 5'd1; maddr[1] = 32'h100; mlen[1] = 8'd3;
        #1;
        tests++;
        if ({dsp_AWREADY_o, AW_AxID_o, AW_crossing_flag_o, AW_shift_en_o, W_shift_en_o, W_mst_id_o}
            !== {3'b010, 7'b01_00001, 1'b0, 1'b1, 1'b1, 2'd1}) begin
            fails++;
            $display("FAIL single_grant: got rdy=%b id=%h x=%b sh=%b%b w=%0d exp rdy=010 id=21 x=0 sh=11 w=1",
                     dsp_AWREADY_o, AW_AxID_o, AW_crossing_flag_o, AW_shift_en_o, W_shift_en_o, W_mst_id_o);
        end
        commit(1, 1);
        valid = '0;
        #1;
        tests++;
        if ({s_AWVALID_o, s_AWID_o, s_AWADDR_o, s_AWLEN_o} !== {1'b1, 7'b01_00001, 32'h100, 8'd3}) begin
            fails++;
            $display("FAIL single_out: got %b/%h/%h/%h exp 1/21/00000100/03",
                     s_AWVALID_o, s_AWID_o, s_AWADDR_o, s_AWLEN_o);
        end
        commit(0, 0);
        commit(0, 0);
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        valid = 3'b111;
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < int'(NM); i++) mid[i] = TW'($urandom);
            g = k % 3;
            #1;
            tests++;
            if ({dsp_AWREADY_o, AW_AxID_o, AW_crossing_flag_o}
                !== {3'(1 << g), MW'(g), mid[g], k != 0}) begin
                fails++;
                $display("FAIL rr_k%0d: got rdy=%b id=%h x=%b exp rdy=%b id=%h x=%b", k,
                         dsp_AWREADY_o, AW_AxID_o, AW_crossing_flag_o,
                         3'(1 << g), {MW'(g), mid[g]}, k != 0);
            end
            commit(1, g);
        end
        valid = '0;
        commit(0, 0);
        commit(0, 0);
    endtask

    task automatic test_crossing();
        logic [SW-1:0] exp_id [3];
        logic [2:0] exp_x;
        int gs [3];
        exp_id[0] = 7'b00_00001; exp_id[1] = 7'b00_00010; exp_id[2] = 7'b10_00010;
        exp_x = 3'b100;
        gs[0] = 0; gs[1] = 0; gs[2] = 2;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            valid = (k < 2) ? 3'b001 : 3'b100;
            mid[gs[k]] = (k == 0) ? 5'd1 : 5'd2;
            #1;
            tests++;
            if ({AW_AxID_o, AW_crossing_flag_o, W_mst_id_o} !== {exp_id[k], exp_x[k], MW'(gs[k])}) begin
                fails++;
                $display("FAIL crossing_k%0d: got id=%h x=%b w=%0d exp id=%h x=%b w=%0d", k,
                         AW_AxID_o, AW_crossing_flag_o, W_mst_id_o, exp_id[k], exp_x[k], gs[k]);
            end
            commit(1, gs[k]);
        end
        valid = '0;
        commit(0, 0);
        commit(0, 0);
    endtask

    task automatic test_backpressure();
        do_reset();
        s_ready = 1'b0;
        valid = 3'b001;
        commit(1, 0);
        valid = 3'b100;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++;
            if ({dsp_AWREADY_o, AW_shift_en_o, W_shift_en_o} !== 5'b0) begin
                fails++;
                $display("FAIL bp_hold_k%0d: got rdy=%b sh=%b%b exp rdy=000 sh=00", k,
                         dsp_AWREADY_o, AW_shift_en_o, W_shift_en_o);
            end
            commit(0, 0);
        end
        s_ready = 1'b1;
        #1;
        tests++;
        if ({dsp_AWREADY_o, AW_AxID_o, AW_crossing_flag_o} !== {3'b100, 2'd2, mid[2], 1'b1}) begin
            fails++;
            $display("FAIL bp_release: got rdy=%b id=%h x=%b exp rdy=100 id=%h x=1",
                     dsp_AWREADY_o, AW_AxID_o, AW_crossing_flag_o, {2'd2, mid[2]});
        end
        commit(1, 2);
        valid = '0;
        commit(0, 0);
        commit(0, 0);
    endtask

    task automatic test_stall();
        do_reset();
        valid = 3'b111;
        commit(1, 0);
        commit(1, 1);
        for (int k = 0; k < 4; k++) begin
            aw_stall = (k < 2);
            w_stall  = (k >= 2);
            #1;
            tests++;
            if ({dsp_AWREADY_o, AW_shift_en_o, W_shift_en_o} !== 5'b0) begin
                fails++;
                $display("FAIL stall_k%0d: got rdy=%b sh=%b%b exp rdy=000 sh=00", k,
                         dsp_AWREADY_o, AW_shift_en_o, W_shift_en_o);
            end
            commit(0, 0);
        end
        aw_stall = 1'b0;
        w_stall  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            tests++;
            if ({dsp_AWREADY_o, W_mst_id_o} !== {(k == 0) ? 3'b100 : 3'b001, (k == 0) ? 2'd2 : 2'd0}) begin
                fails++;
                $display("FAIL stall_resume_k%0d: got rdy=%b w=%0d exp rdy=%b", k,
                         dsp_AWREADY_o, W_mst_id_o, (k == 0) ? 3'b100 : 3'b001);
            end
            commit(1, (k == 0) ? 2 : 0);
        end
        valid = '0;
        commit(0, 0);
        commit(0, 0);
    endtask

    task automatic test_async_reset();
        do_reset();
        s_ready = 1'b0;
        valid = 3'b010;
        commit(1, 1);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        tests++;
        if ({s_AWVALID_o, s_AWID_o, s_AWADDR_o, s_AWLEN_o, dsp_AWREADY_o,
             AW_shift_en_o, W_shift_en_o, AW_AxID_o, W_mst_id_o, AW_crossing_flag_o} !== '0) begin
            fails++;
            $display("FAIL async_reset: got v=%b id=%h a=%h l=%h rdy=%b sh=%b%b ax=%h w=%0d x=%b exp zeros",
                     s_AWVALID_o, s_AWID_o, s_AWADDR_o, s_AWLEN_o, dsp_AWREADY_o,
                     AW_shift_en_o, W_shift_en_o, AW_AxID_o, W_mst_id_o, AW_crossing_flag_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s_ready = 1'b1;
        valid = 3'b111;
        #1;
        tests++;
        if ({dsp_AWREADY_o, AW_crossing_flag_o} !== {3'b001, 1'b0}) begin
            fails++;
            $display("FAIL async_reset_prio: got rdy=%b x=%b exp rdy=001 x=0",
                     dsp_AWREADY_o, AW_crossing_flag_o);
        end
        commit(1, 0);
        valid = '0;
        commit(0, 0);
        commit(0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_crossing();
        test_backpressure();
        test_stall();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sa_aw_arbiter.md
Name: sa_AW_arbiter

Overview:
Slave-side write-address arbiter for one slave port of the AXI4 interconnect.
- Picks one of MST_AMT dispatcher AW requests per cycle using round-robin.
- Widens AWID to the slave ID {master index, master AWID} and drives the slave AW channel through a one-entry registered output stage.
- On every grant, pushes ordering information into the write-response tracker (sa_WRESP_channel) and the write-data order queue.

Parameters:
MST_AMT, 3, number of master-side requesters
MST_ID_W, $clog2(MST_AMT), width of the master index
TRANS_MST_ID_W, 5, master transaction ID width
TRANS_SLV_ID_W, TRANS_MST_ID_W+MST_ID_W, slave transaction ID width
ADDR_W, 32, address width
LEN_W, 8, AWLEN width

Ports:
ACLK_i  in  1  clock
ARESETn_i  in  1  asynchronous active-low reset
dsp_AWID_i  in  TRANS_MST_ID_W*MST_AMT  packed per-master AWID, master i at [W*(i+1)-1-:W]
dsp_AWADDR_i  in  ADDR_W*MST_AMT  packed per-master AWADDR
dsp_AWLEN_i  in  LEN_W*MST_AMT  packed per-master AWLEN
dsp_AWVALID_i  in  MST_AMT  per-master AWVALID
dsp_AWREADY_o  out  MST_AMT  per-master AWREADY, one-hot or zero
s_AWID_o  out  TRANS_SLV_ID_W  slave AWID = {mst_idx, AWID}
s_AWADDR_o  out  ADDR_W  slave AWADDR
s_AWLEN_o  out  LEN_W  slave AWLEN
s_AWVALID_o  out  1  slave AWVALID
s_AWREADY_i  in  1  slave AWREADY
AW_AxID_o  out  TRANS_SLV_ID_W  ID pushed to the write-response tracker
AW_crossing_flag_o  out  1  granted master differs from the previous granted master
AW_shift_en_o  out  1  push strobe to the write-response tracker
AW_stall_i  in  1  write-response tracker full
W_mst_id_o  out  MST_ID_W  granted master index for write-data ordering
W_shift_en_o  out  1  push strobe to the write-data order queue
W_stall_i  in  1  write-data order queue full

Behaviour:
- Reset is asynchronous. While ARESETn_i=0:
  - s_AWVALID_o=0, s_AWID_o/ADDR/LEN=0.
  - dsp_AWREADY_o=0, AW_shift_en_o=0, W_shift_en_o=0, AW_crossing_flag_o=0, AW_AxID_o=0, W_mst_id_o=0.
  - rr_ptr=MST_AMT-1, last_mst=0, last_valid=0.
- A reset asserted mid-transaction drops any pending output entry; it is not replayed.
- Output stage is one entry. It can load when slot_free = !s_AWVALID_o | s_AWREADY_i.
- grant_en = slot_free & !AW_stall_i & !W_stall_i & |dsp_AWVALID_i.
- Round-robin arbitration (combinational):
  - Search for the first valid master starting at (rr_ptr+1) mod MST_AMT and wrapping upward.
  - Master 0 wins first after reset.
- dsp_AWREADY_o[g] = grant_en for the selected g; all other bits are 0. Accept is combinational in the same cycle, so a dispatcher handshake completes that cycle.
- On the accept clock edge:
  - s_AWID_o <= {g, AWID[g]}; s_AWADDR_o and s_AWLEN_o load from master g.
  - s_AWVALID_o <= 1.
  - rr_ptr <= g, last_mst <= g, last_valid <= 1.
- On an edge with s_AWVALID_o & s_AWREADY_i and no new grant, s_AWVALID_o <= 0.
- Back-to-back: a grant in the same cycle as a slave handshake reloads the stage, giving 1 AW/cycle sustained.
- Slave payload stays stable while s_AWVALID_o=1 & !s_AWREADY_i (AXI rule).
- Tracker push outputs are combinational and valid in the grant cycle:
  - AW_shift_en_o = W_shift_en_o = grant_en.
  - AW_AxID_o = {g, AWID[g]}; W_mst_id_o = g.
  - AW_crossing_flag_o = last_valid & (g != last_mst).
  - The first grant after reset has the flag = 0.
- Stall: either stall input forces dsp_AWREADY_o=0 and no push. The rr_ptr and output stage are unaffected, and a pending slave entry still drains.
- Only one grant per cycle. The pointer advances only on an actual grant.
- If no valid requests are present, the pointer holds.
- MST_AMT=1: rr logic degenerates to always granting master 0, with MST_ID_W treated as 1-bit zero.

Test Plan:
1. Reset, then master 1 alone valid with AWID=5'd1, AWADDR=0x100, AWLEN=3, s_AWREADY_i=1 -> dsp_AWREADY_o=3'b010 in the same cycle; AW_AxID_o={2'd1,5'd1}; crossing=0. Next cycle s_AWID_o={2'd1,5'd1}, s_AWVALID_o=1, s_AWADDR_o=0x100.
2. All 3 masters valid continuously, s_AWREADY_i=1 -> grant order 0,1,2,0,… at 1 per cycle; crossing=0 on the first grant, 1 on every later one.
3. Master 0 issues back-to-back AWs with IDs 5'd1 then 5'd2 -> crossing=0 on both. Then master 2 issues ID 5'd2 -> AW_AxID_o={2'd2,5'd2}, crossing=1.
4. s_AWREADY_i=0 for 4 cycles with an entry loaded and master 2 valid -> s_AW* held stable and dsp_AWREADY_o=0. When s_AWREADY_i rises, master 2 is granted in that same cycle.
5. AW_stall_i=1 (then W_stall_i=1) with all masters valid -> no dsp_AWREADY_o and no shift_en; rr_ptr unchanged. On release, the grant resumes at the expected next master.
6. Assert ARESETn_i low while s_AWVALID_o=1 -> all outputs reach their reset values immediately without waiting for a clock edge; after release, master 0 has priority.
